// File: rtl/pipe_ctrl_mw_pkg.sv
// Shared constants for the pipeline stall controller: stage indices, stall/flush
// levels and the memory wait-state FSM encoding.
package pipe_ctrl_mw_pkg;

  localparam int INST_ADDR_BUS_W = 32;

  localparam int STAGE_PC    = 0;
  localparam int STAGE_IFID  = 1;
  localparam int STAGE_IDEX  = 2;
  localparam int STAGE_EXMEM = 3;
  localparam int STAGE_MEMWB = 4;
  localparam int STAGE_WB    = 5;

  localparam logic STOP     = 1'b1;
  localparam logic NO_STOP  = 1'b0;
  localparam logic FLUSH_ON = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } wait_state_e;

endpackage

// File: rtl/pipe_ctrl_mw_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
  import pipe_ctrl_mw_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl_mw.sv
// Pipeline stall controller: thermometer stall vector, memory wait-state FSM,
// deferred flush sequencing and saturating stall/flush counters.
module pipe_ctrl_mw
  import pipe_ctrl_mw_pkg::*;
#(
  parameter int NUM_STAGES = STAGE_WB + 1,
  parameter int MEM_STAGE  = STAGE_MEMWB,
  parameter int MEM_WAIT   = 2,
  parameter int ADDR_W     = INST_ADDR_BUS_W,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stallreq_i,
  input  logic                  mem_req_i,
  input  logic                  flush_i,
  input  logic [ADDR_W-1:0]     new_pc_i,
  input  logic                  clr_cnt_i,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic                  mem_done_o,
  output logic                  flush_o,
  output logic [ADDR_W-1:0]     new_pc_o,
  output logic [CNT_W-1:0]      stall_cycles_o,
  output logic [CNT_W-1:0]      flush_count_o
);

  wait_state_e           state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic [ADDR_W-1:0]     pend_pc_q, pend_pc_d;
  logic                  mem_wait_stall;
  logic                  mem_done;
  logic [NUM_STAGES-1:0] req_eff;
  logic [NUM_STAGES-1:0] stall_raw;
  logic                  deliverable;

  always_comb begin
    req_eff            = stallreq_i;
    req_eff[MEM_STAGE] = stallreq_i[MEM_STAGE] | mem_wait_stall;
  end

  // Stage k stalls whenever it or any older stage requests a stall.
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stall
    assign stall_raw[gi] = |req_eff[NUM_STAGES-1:gi];
    if (gi < MEM_STAGE) begin : g_young
      assign stall_o[gi] = (rst || flush_o) ? NO_STOP : stall_raw[gi];
    end else begin : g_old
      assign stall_o[gi] = rst ? NO_STOP : stall_raw[gi];
    end
  end

  assign deliverable = ~|req_eff[NUM_STAGES-1:MEM_STAGE];
  assign flush_o     = ~rst & deliverable & (pend_q | flush_i) ? FLUSH_ON : 1'b0;
  assign new_pc_o    = flush_o ? (pend_q ? pend_pc_q : new_pc_i) : '0;
  assign mem_done_o  = mem_done & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_req_i && (MEM_WAIT > 0)) begin
          cnt_d   = 4'(MEM_WAIT - 1);
          state_d = (MEM_WAIT > 1) ? ST_WAIT : ST_DONE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_DONE;
      end
      // An older stage holding the memory stage keeps the result on the bus.
      ST_DONE: state_d = stall_raw[MEM_STAGE] ? ST_DONE : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_wait_stall = 1'b0;
    mem_done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_req_i) begin
          if (MEM_WAIT == 0) mem_done = 1'b1;
          else               mem_wait_stall = STOP;
        end
      end
      ST_WAIT: mem_wait_stall = STOP;
      ST_DONE: mem_done = 1'b1;
      default: ;
    endcase
  end

  // Oldest flush wins: a pending flush masks any newer request until delivered.
  always_comb begin
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    if (pend_q) begin
      if (deliverable) pend_d = 1'b0;
    end else if (flush_i && !deliverable) begin
      pend_d    = 1'b1;
      pend_pc_d = new_pc_i;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (stall_o[STAGE_PC]),
    .clr_i (clr_cnt_i),
    .cnt_o (stall_cycles_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (flush_o),
    .clr_i (clr_cnt_i),
    .cnt_o (flush_count_o)
  );

endmodule

// File: tb/tb_pipe_ctrl_mw.sv
// Bench for pipe_ctrl_mw: two instances (MEM_WAIT=2/CNT_W=4 and MEM_WAIT=0/CNT_W=32)
// driven in lockstep and checked against a cycle-level behavioural model.
module tb_pipe_ctrl_mw;

  localparam int NS = 6;
  localparam int MS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stallreq;
  logic        mem_req, flush, clr;
  logic [31:0] new_pc;

  logic [5:0]  st_a, st_b;
  logic        done_a, done_b, fl_a, fl_b;
  logic [31:0] pc_a, pc_b;
  logic [3:0]  sc_a, fc_a;
  logic [31:0] sc_b, fc_b;

  always #5 clk = ~clk;

  pipe_ctrl_mw #(.NUM_STAGES(NS), .MEM_STAGE(MS), .MEM_WAIT(2), .ADDR_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .stallreq_i(stallreq), .mem_req_i(mem_req), .flush_i(flush),
    .new_pc_i(new_pc), .clr_cnt_i(clr), .stall_o(st_a), .mem_done_o(done_a),
    .flush_o(fl_a), .new_pc_o(pc_a), .stall_cycles_o(sc_a), .flush_count_o(fc_a)
  );

  pipe_ctrl_mw #(.NUM_STAGES(NS), .MEM_STAGE(MS), .MEM_WAIT(0), .ADDR_W(32), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .stallreq_i(stallreq), .mem_req_i(mem_req), .flush_i(flush),
    .new_pc_i(new_pc), .clr_cnt_i(clr), .stall_o(st_b), .mem_done_o(done_b),
    .flush_o(fl_b), .new_pc_o(pc_b), .stall_cycles_o(sc_b), .flush_count_o(fc_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state per instance: remaining stall cycles of the access in flight,
  // whether the completion cycle is being held, and the oldest undelivered flush.
  int          mw [2]  = '{2, 0};
  longint      cap [2] = '{15, 64'hFFFF_FFFF};
  int          busy [2];
  bit          donep [2];
  bit          pend [2];
  logic [31:0] ppc [2];
  longint      sc [2];
  longint      fc [2];
  int          e_stall [2];
  bit          e_done [2];
  bit          e_flush [2];
  logic [31:0] e_pc [2];
  bit          hold [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_comb(input int m);
    int eff, j, mws;
    bit deliv;
    e_done[m] = 0; e_flush[m] = 0; e_pc[m] = '0; e_stall[m] = 0; hold[m] = 0;
    if (rst) begin
      busy[m] = 0; donep[m] = 0; pend[m] = 0; ppc[m] = '0; sc[m] = 0; fc[m] = 0;
      return;
    end
    mws = 0;
    if (donep[m])         e_done[m] = 1;
    else if (busy[m] > 0) mws = 1;
    else if (mem_req) begin
      if (mw[m] == 0) e_done[m] = 1;
      else            mws = 1;
    end
    eff = int'(stallreq);
    if (mws != 0) eff = eff | (1 << MS);
    j = -1;
    for (int k = 0; k < NS; k++) if (((eff >> k) & 1) != 0) j = k;
    e_stall[m] = (j < 0) ? 0 : ((1 << (j + 1)) - 1);
    hold[m]    = ((e_stall[m] >> MS) & 1) != 0;
    deliv      = (eff >> MS) == 0;
    e_flush[m] = deliv && (pend[m] || flush);
    if (e_flush[m]) begin
      e_pc[m]    = pend[m] ? ppc[m] : new_pc;
      e_stall[m] = e_stall[m] & ~((1 << MS) - 1);
    end
  endtask

  task automatic model_edge(input int m);
    if (rst) return;
    sc[m] = clr ? 0 : ((sc[m] + (e_stall[m] & 1)) > cap[m] ? cap[m] : sc[m] + (e_stall[m] & 1));
    fc[m] = clr ? 0 : ((fc[m] + longint'(e_flush[m])) > cap[m] ? cap[m] : fc[m] + longint'(e_flush[m]));
    if (pend[m]) begin
      if (e_flush[m]) pend[m] = 0;
    end else if (flush && !e_flush[m]) begin
      pend[m] = 1;
      ppc[m]  = new_pc;
    end
    if (donep[m]) donep[m] = hold[m];
    else if (busy[m] > 0) begin
      busy[m]--;
      if (busy[m] == 0) donep[m] = 1;
    end else if (mem_req && mw[m] > 0) begin
      busy[m] = mw[m] - 1;
      if (busy[m] == 0) donep[m] = 1;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      model_comb(m);
      chk($sformatf("stall_o[%0d]", m),  (m == 0) ? st_a : st_b, 64'(e_stall[m]));
      chk($sformatf("mem_done[%0d]", m), (m == 0) ? done_a : done_b, 64'(e_done[m]));
      chk($sformatf("flush_o[%0d]", m),  (m == 0) ? fl_a : fl_b, 64'(e_flush[m]));
      chk($sformatf("new_pc_o[%0d]", m), (m == 0) ? pc_a : pc_b, 64'(e_pc[m]));
      chk($sformatf("stall_cnt[%0d]", m), (m == 0) ? 64'(sc_a) : 64'(sc_b), sc[m]);
      chk($sformatf("flush_cnt[%0d]", m), (m == 0) ? 64'(fc_a) : 64'(fc_b), fc[m]);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int m = 0; m < 2; m++) model_edge(m);
    #1;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic drive(input logic r, input logic [5:0] sr, input logic mr, input logic f,
                       input logic [31:0] pc, input logic c);
    rst = r; stallreq = sr; mem_req = mr; flush = f; new_pc = pc; clr = c;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    tick(); tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();

    // priority decode
    drive(0, 6'b000100, 0, 0, 0, 0); settle(); chk("decode_000100", st_a, 6'b000111); advance();
    drive(0, 6'b100001, 0, 0, 0, 0); settle(); chk("decode_100001", st_a, 6'b111111); advance();
    drive(0, 6'b000000, 0, 0, 0, 0); settle(); chk("decode_zero", st_a, 6'b000000); advance();

    // wait states
    drive(0, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 1, 0, 0, 0); settle();
    chk("wait_t", st_a, 6'b011111); chk("mw0_done_t", done_b, 1); chk("mw0_stall_t", st_b, 0);
    advance();
    settle(); chk("wait_t1", st_a, 6'b011111); advance();
    drive(0, 0, 0, 0, 0, 0); settle();
    chk("done_t2", done_a, 1); chk("done_t2_stall", st_a, 0); chk("stall_cycles_2", sc_a, 2);
    advance();
    tick();

    // deferred flush, second flush ignored while pending
    drive(0, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 1, 1, 32'h40, 0); settle(); chk("defer_t", fl_a, 0); advance();
    drive(0, 0, 0, 1, 32'h80, 0); settle(); chk("defer_t1", fl_a, 0); advance();
    drive(0, 0, 0, 0, 0, 0); settle();
    chk("defer_done_fl", fl_a, 1); chk("defer_done_pc", pc_a, 32'h40); advance();
    settle(); chk("defer_after", fl_a, 0); chk("flush_count_1", fc_a, 1); advance();

    // immediate flush
    drive(0, 6'b000011, 0, 1, 32'h100, 0); settle();
    chk("imm_flush", fl_a, 1); chk("imm_stall", st_a, 0); chk("imm_pc", pc_a, 32'h100);
    advance();

    // saturation and clear
    drive(0, 0, 0, 0, 0, 1); tick();
    drive(0, 6'b000001, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) tick();
    settle(); chk("sat_15", sc_a, 15); advance();
    drive(0, 6'b000001, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0); settle(); chk("clr_0", sc_a, 0); advance();

    // reset mid-wait with pending flush
    drive(0, 0, 1, 1, 32'h200, 0); tick();
    drive(1, 0, 0, 1, 32'h300, 0); settle();
    chk("rst_stall", st_a, 0); chk("rst_flush", fl_a, 0); chk("rst_done", done_a, 0);
    chk("rst_pc", pc_a, 0);
    advance();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      settle(); chk("post_rst_flush", fl_a, 0); chk("post_rst_stall", st_a, 0); advance();
    end

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic [5:0] sr;
      sr = '0;
      for (int b = 0; b < NS; b++) if ($urandom_range(0, 7) == 0) sr[b] = 1'b1;
      drive(($urandom_range(0, 199) == 0), sr, ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 4) == 0), $urandom, ($urandom_range(0, 59) == 0));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_mw.md
Name: pipe_ctrl_mw

Overview:
- Parametrised successor to the pipeline stall controller.
- Generates the per-stage stall vector for an N-stage pipeline from per-stage stall requests.
- Adds three functions on top of plain stall generation:
  - an internal wait-state FSM that holds the memory stage for a fixed number of cycles per RAM access;
  - precise flush sequencing that defers a younger flush until the memory stage completes;
  - saturating stall/flush performance counters.
- Sits beside the datapath in the core top level and drives every pipeline register's stall input.

Parameters:
NUM_STAGES, 6, width of stall vector; bit 0 = PC, 1 = IF/ID, 2 = ID/EX, 3 = EX/MEM, 4 = MEM/WB, 5 = WB
MEM_STAGE, 4, index of the stage that performs RAM accesses (must be < NUM_STAGES)
MEM_WAIT, 2, stall cycles per RAM access (0..15; 0 = single-cycle RAM)
ADDR_W, 32, width of flush target PC
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
stallreq_i  in  NUM_STAGES  per-stage stall request, bit k from stage k, combinational
mem_req_i  in  1  memory stage holds a load/store this cycle
flush_i  in  1  flush request from a stage younger than MEM_STAGE (branch/exception)
new_pc_i  in  ADDR_W  flush target, valid with flush_i
clr_cnt_i  in  1  synchronous clear of both counters
stall_o  out  NUM_STAGES  stall vector to pc and pipeline registers
mem_done_o  out  1  memory access completes this cycle
flush_o  out  1  flush all stages younger than MEM_STAGE this cycle
new_pc_o  out  ADDR_W  flush target, valid with flush_o
stall_cycles_o  out  CNT_W  cycles with stall_o[0]=1, saturating
flush_count_o  out  CNT_W  number of flush_o pulses, saturating

Behaviour:
- Reset (async, rst=1):
  - stall_o=0, flush_o=0, mem_done_o=0, new_pc_o=0.
  - FSM=IDLE, wait counter=0, flush pending=0, pending PC=0, both counters=0.
- Effective request:
  - req_eff = stallreq_i, with bit MEM_STAGE additionally OR'd with mem_wait_stall.
  - j = highest set bit of req_eff.
  - stall_o[k] = 1 for k<=j, 0 for k>j; all zero if req_eff=0.
  - Combinational, zero latency.
  - stall_o[j]=1 with stall_o[j+1]=0 means stage j+1 inserts a bubble.
- Wait-state FSM (states IDLE, WAIT, DONE); 4-bit counter cnt:
  - IDLE:
    - mem_req_i=0: no action.
    - mem_req_i=1 and MEM_WAIT=0: mem_done_o=mem_req_i, stay IDLE.
    - mem_req_i=1 and MEM_WAIT>=1: mem_wait_stall=1, cnt<=MEM_WAIT-1; next state WAIT if MEM_WAIT>1, else DONE.
  - WAIT: mem_wait_stall=1, cnt<=cnt-1; when cnt==1, next state DONE.
  - DONE: mem_wait_stall=0, mem_done_o=1.
    - Stay in DONE while stall_o[MEM_STAGE]=1 (held by an older stage).
    - Otherwise go to IDLE.
  - Result: exactly MEM_WAIT stall cycles per access; back-to-back accesses are separated by the DONE cycle.
  - stallreq_i does not pause cnt.
- Flush:
  - Flush is deliverable when req_eff[NUM_STAGES-1:MEM_STAGE]==0.
  - pending=0, flush_i=1, deliverable: flush_o=1, new_pc_o=new_pc_i (combinational).
  - pending=0, flush_i=1, not deliverable: latch pending=1 and pending PC; flush_o=0.
  - pending=1: flush_o=1 and new_pc_o=pending PC in the first deliverable cycle; pending clears on that edge.
  - While pending, further flush_i is ignored (oldest flush wins).
  - When flush_o=1: stall_o bits < MEM_STAGE are forced 0 so the fetch side can redirect.
- Counters:
  - Increment on each clock edge, capped at 2^CNT_W-1.
  - clr_cnt_i has priority over increment; increments in the clear cycle are lost.
- Reset mid-operation: any wait or pending flush is discarded; no flush_o after reset release.

Decomposition:
- Shared package/defines: stage index constants (STAGE_PC..STAGE_WB), FSM state encodings, Stop/NoStop and FlushOn values; the ADDR_W default comes from the existing instruction-address-bus define.
- One sub-module: sat_counter (CNT_W, inc, clr), instantiated twice.
- Stall vector generation and FSM stay in pipe_ctrl_mw.

Test Plan:
1. Reset: rst=1 mid-WAIT with pending flush → all outputs 0 immediately; after release, no flush_o and FSM in IDLE.
2. Priority decode: stallreq_i=6'b000100 → stall_o=6'b000111; stallreq_i=6'b100001 → stall_o=6'b111111; stallreq_i=0 → stall_o=0.
3. Wait states, MEM_WAIT=2: mem_req_i held from cycle t →
   - stall_o=6'b011111 at t and t+1;
   - mem_done_o=1 with stall_o=0 at t+2;
   - stall_cycles_o=2 afterwards.
   - Repeat with MEM_WAIT=0 → no stall, mem_done_o=1 at t.
4. Deferred flush: flush_i=1, new_pc_i=32'h0000_0040 during the WAIT cycle →
   - flush_o=0 that cycle;
   - flush_o=1, new_pc_o=32'h40 at DONE;
   - a second flush_i=1, new_pc_i=32'h80 while pending is ignored;
   - flush_count_o=1.
5. Immediate flush with stallreq_i=6'b000011, no mem wait → flush_o=1 and stall_o=0 in the same cycle.
6. Saturation: CNT_W=4, stall held 20 cycles → stall_cycles_o sticks at 15; clr_cnt_i=1 → 0 on next edge.
